exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, between decode (ds) and memory (ms).
//  - Evaluates the ALU op and MULT/MULTU; runs DIV/DIVU on a multi-cycle iterative divider.
//  - Owns the HI/LO registers and issues data-SRAM requests for LW/SW.
//  - Publishes es_valid plus its output bus so decode can forward and detect load-use hazards.
// PARAMETERS
//  DIV_STEPS  32  divider iterations per DIV/DIVU (one quotient bit per cycle)
//  Bus widths come from mycpu.h: DS_TO_ES_BUS_WD=145, ES_TO_MS_BUS_WD=71.
// PORTS
//  clk             in   1    clock
//  reset           in   1    reset, synchronous, active-high
//  ms_allowin      in   1    memory stage can accept
//  es_allowin      out  1    !es_valid || (es_ready_go && ms_allowin)
//  ds_to_es_valid  in   1    decode offers an instruction
//  ds_to_es_bus    in   145  {alu_op[144:133],load_op 132,mul 131,mulu 130,div 129,divu 128,
//                            src1_sa 127,src1_pc 126,src2_simm 125,src2_zimm 124,src2_8 123,
//                            gr_we 122,mem_we 121,hi_re 120,lo_re 119,hi_we 118,lo_we 117,
//                            dest[116:112],imm[111:96],rs_val[95:64],rt_val[63:32],pc[31:0]}
//  es_to_ms_valid  out  1    es_valid && es_ready_go
//  es_valid        out  1    stage occupied (to decode, for forwarding)
//  es_to_ms_bus    out  71   {load_op 70,gr_we 69,dest[68:64],es_result[63:32],pc[31:0]}
//  data_sram_en    out  1    SRAM request enable
//  data_sram_wen   out  4    byte write enables
//  data_sram_addr  out  32   byte address (= alu result)
//  data_sram_wdata out  32   rt_val
// BEHAVIOUR
//  - Reset: es_valid=0, HI=LO=0, divider IDLE; hence es_to_ms_valid=0, data_sram_en=0, wen=0.
//  - Bus register captures ds_to_es_bus when ds_to_es_valid && es_allowin.
//    es_valid <= ds_to_es_valid whenever es_allowin.
//  - Operand selection:
//    src1 = src1_sa ? {27'b0,imm[10:6]} : src1_pc ? pc : rs_val.
//    src2 = src2_simm ? sext(imm) : src2_zimm ? zext(imm) : src2_8 ? 32'd8 : rt_val.
//  - alu_op one-hot, bits 0..11: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
//    Shifts use src2 shifted by src1[4:0]. LUI = {imm,16'b0}. Add/sub wrap; no overflow trap.
//  - es_result = hi_re ? HI : lo_re ? LO : alu_result.
//  - MULT/MULTU: single-cycle 32x32->64 product (signed/unsigned); {HI,LO} <= product.
//  - MTHI: HI <= rs_val. MTLO: LO <= rs_val.
//  - HI/LO write strobe = es_valid && es_ready_go && ms_allowin (handoff cycle only).
//    So an MFHI/MFLO that enters ES next cycle sees the new value.
//  - Divider FSM:
//    IDLE -> BUSY when es_valid && (div||divu). start = rs_val (dividend), rt_val (divisor).
//    BUSY counts 0..DIV_STEPS-1, then -> DONE.
//    DONE -> IDLE on handoff (es_valid && ms_allowin).
//    es_ready_go = !(div||divu) || state==DONE. A DIV occupies ES exactly 34 cycles if ms_allowin=1.
//    On exit: LO <= quotient, HI <= remainder. Signed ops divide magnitudes, then negate:
//    quotient negated if signs differ; remainder takes the dividend's sign.
//    Divide by zero: completes with the same latency, no hang.
//    DIVU x/0 gives Q=32'hFFFFFFFF, R=x; DIV x/0 result is unspecified.
//    Stall in DONE (ms_allowin=0) holds the result; no restart.
//  - Memory: data_sram_en = es_valid && ms_allowin && (load_op||mem_we).
//    wen = {4{mem_we && es_valid && ms_allowin}}. A stalled store never writes twice.
//  - Reset while divider BUSY: FSM returns to IDLE next edge and the result is discarded.
// STRUCTURE
//  - mycpu.h: bus width defines, alu_op bit indices, divider state encodings.
//  - Sub-modules:
//    alu: combinational.
//    iter_div: start/busy/done handshake, signed flag, 32-bit quotient and remainder.
//    It holds its outputs in DONE until ack.
// TESTING
//  1. ADDU rs=5, rt=7, single cycle -> es_result=12, es_to_ms_valid high the cycle after capture.
//  2. MULT rs=-3, rt=4, then MFHI, MFLO back-to-back -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF4.
//  3. DIVU 100/7 -> es_ready_go low 33 cycles, high on the 34th; LO=14, HI=2.
//     A following MFLO reads 14.
//  4. DIV -7/2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
//     DIVU 9/0 -> LO=32'hFFFFFFFF, HI=9, same latency.
//  5. SW addr=0x100, data=0xA5 with ms_allowin held low 3 cycles -> wen=4'hF asserted exactly once,
//     in the cycle ms_allowin rises.
//  6. Assert reset at DIV iteration 10 -> es_valid=0 and FSM IDLE next cycle.
//     A new DIVU 8/2 after reset -> LO=4, HI=0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions, divider state encoding and the
// combinational ALU used by the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 145;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int DIV_STEPS       = 32;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // alu_op is one-hot, so OR-ing the enabled terms yields the selected result.
  function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [15:0] imm);
    logic [31:0] r;
    r = '0;
    if (op[ALU_ADD])  r |= a + b;
    if (op[ALU_SUB])  r |= a - b;
    if (op[ALU_SLT])  r |= {31'b0, $signed(a) < $signed(b)};
    if (op[ALU_SLTU]) r |= {31'b0, a < b};
    if (op[ALU_AND])  r |= a & b;
    if (op[ALU_NOR])  r |= ~(a | b);
    if (op[ALU_OR])   r |= a | b;
    if (op[ALU_XOR])  r |= a ^ b;
    if (op[ALU_SLL])  r |= b << a[4:0];
    if (op[ALU_SRL])  r |= b >> a[4:0];
    if (op[ALU_SRA])  r |= $unsigned($signed(b) >>> a[4:0]);
    if (op[ALU_LUI])  r |= {imm, 16'b0};
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// Iterative restoring divider, one quotient bit per cycle; signed ops divide
// magnitudes and fix signs on the way out. Results are held in DONE until ack.
//   state    | meaning
//   DIV_IDLE | waiting for start
//   DIV_BUSY | iterating, cnt counts down to terminal 0
//   DIV_DONE | quotient/remainder valid, waiting for ack
module exe_stage_div
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] quo_r, rem_r, dvs_r;
  logic        neg_q, neg_r;
  logic [31:0] mag_a, mag_b;
  logic [32:0] diff;

  assign mag_a = (signed_op && dividend[31]) ? -dividend : dividend;
  assign mag_b = (signed_op && divisor[31])  ? -divisor  : divisor;
  // Partial remainder stays below the divisor, so bit 32 is a clean borrow flag.
  assign diff  = {rem_r, quo_r[31]} - {1'b0, dvs_r};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state <= DIV_BUSY;
          cnt   <= 5'(DIV_STEPS - 1);
          quo_r <= mag_a;
          rem_r <= '0;
          dvs_r <= mag_b;
          neg_q <= signed_op && (dividend[31] ^ divisor[31]);
          neg_r <= signed_op && dividend[31];
        end
        DIV_BUSY: begin
          if (!diff[32]) begin
            rem_r <= diff[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= {rem_r[30:0], quo_r[31]};
            quo_r <= {quo_r[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -quo_r : quo_r;
  assign remainder = neg_r ? -rem_r : rem_r;

endmodule

// File: rtl/exe_stage.sv
// Pipeline execute stage: ALU, MULT/MULTU, iterative DIV/DIVU, HI/LO ownership
// and data-SRAM request generation for loads and stores.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic                       es_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic [DS_TO_ES_BUS_WD-1:0] bus_r;
  logic [11:0] alu_op;
  logic        load_op, mul, mulu, div, divu, src1_sa, src1_pc;
  logic        src2_simm, src2_zimm, src2_8, gr_we, mem_we;
  logic        hi_re, lo_re, hi_we, lo_we;
  logic [4:0]  dest;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, pc;

  assign {alu_op, load_op, mul, mulu, div, divu, src1_sa, src1_pc,
          src2_simm, src2_zimm, src2_8, gr_we, mem_we,
          hi_re, lo_re, hi_we, lo_we, dest, imm, rs_val, rt_val, pc} = bus_r;

  logic [31:0] src1, src2, alu_result, es_result, hi, lo, quo, rem;
  logic [63:0] prod;
  logic        es_ready_go, div_done, hilo_we, handoff;

  assign es_ready_go    = !(div || divu) || div_done;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign handoff        = es_valid && ms_allowin;
  assign hilo_we        = handoff && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
    if (ds_to_es_valid && es_allowin) bus_r <= ds_to_es_bus;
  end

  assign src1 = src1_sa ? {27'b0, imm[10:6]} : src1_pc ? pc : rs_val;
  assign src2 = src2_simm ? {{16{imm[15]}}, imm} :
                src2_zimm ? {16'b0, imm} :
                src2_8    ? 32'd8 : rt_val;

  assign alu_result = alu_calc(alu_op, src1, src2, imm);
  assign es_result  = hi_re ? hi : lo_re ? lo : alu_result;

  // Low 64 bits of the product of the extended operands give the exact result.
  assign prod = mul ? {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val}
                    : {32'b0, rs_val} * {32'b0, rt_val};

  exe_stage_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (es_valid && (div || divu)),
    .signed_op (div),
    .dividend  (rs_val),
    .divisor   (rt_val),
    .ack       (handoff),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (hilo_we) begin
      if (mul || mulu) begin
        {hi, lo} <= prod;
      end else if (div || divu) begin
        lo <= quo;
        hi <= rem;
      end else begin
        if (hi_we) hi <= rs_val;
        if (lo_we) lo <= rs_val;
      end
    end
  end

  assign es_to_ms_bus    = {load_op, gr_we, dest, es_result, pc};
  assign data_sram_en    = handoff && (load_op || mem_we);
  assign data_sram_wen   = {4{mem_we && handoff}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rt_val;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, MULT/MFHI/MFLO, divider latency and
// results, stalled store, and reset during a divide.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset, ms_allowin, ds_to_es_valid;
  logic [144:0] ds_to_es_bus;
  logic         es_allowin, es_to_ms_valid, es_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;

  localparam logic [15:0] F_LOAD = 16'h8000, F_MUL  = 16'h4000, F_MULU = 16'h2000,
                          F_DIV  = 16'h1000, F_DIVU = 16'h0800, F_SA   = 16'h0400,
                          F_PC   = 16'h0200, F_SIMM = 16'h0100, F_ZIMM = 16'h0080,
                          F_S8   = 16'h0040, F_GRWE = 16'h0020, F_MEMWE= 16'h0010,
                          F_HIRE = 16'h0008, F_LORE = 16'h0004, F_HIWE = 16'h0002,
                          F_LOWE = 16'h0001;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_valid        (es_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (data_sram_wen == 4'hF) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [144:0] mk(input logic [11:0] aop, input logic [15:0] fl,
                                      input logic [15:0] imm, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] pc);
    return {aop, fl, 5'd3, imm, rs, rt, pc};
  endfunction

  // Called on a negedge; returns on the negedge after the instruction is captured.
  task automatic send(input logic [144:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(posedge clk);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
  endtask

  task automatic alu_case(input string tag, input logic [11:0] aop, input logic [15:0] fl,
                          input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [31:0] exp);
    send(mk(aop, fl, imm, rs, rt, pc));
    chk(tag, es_to_ms_bus[63:32], exp);
  endtask

  task automatic div_case(input string tag, input logic [15:0] fl, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
    int n;
    n = 0;
    send(mk(12'h000, fl, 16'h0, rs, rt, 32'h0));
    while (!es_to_ms_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lowcycles"}, n, 33);
    alu_case({tag, "_mflo"}, 12'h000, F_LORE | F_GRWE, 16'h0, 32'h0, 32'h0, 32'h0, exp_lo);
    alu_case({tag, "_mfhi"}, 12'h000, F_HIRE | F_GRWE, 16'h0, 32'h0, 32'h0, 32'h0, exp_hi);
  endtask

  initial begin
    int wr_base;
    logic [31:0] wen_seen;
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_es_valid", es_valid, 0);
    chk("rst_to_ms_valid", es_to_ms_valid, 0);
    chk("rst_sram_en", data_sram_en, 0);
    chk("rst_wen", data_sram_wen, 0);
    chk("rst_div_state", 32'(dut.u_div.state), 32'(DIV_IDLE));
    reset = 1'b0;

    alu_case("rst_hi", 12'h000, F_HIRE, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    alu_case("rst_lo", 12'h000, F_LORE, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    alu_case("addu", 12'h001, F_GRWE, 16'h0, 32'd5, 32'd7, 32'h0, 32'd12);
    chk("addu_to_ms_valid", es_to_ms_valid, 1);
    chk("addu_dest", es_to_ms_bus[68:64], 3);
    alu_case("sub",  12'h002, F_GRWE, 16'h0, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE);
    alu_case("slt",  12'h004, F_GRWE, 16'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1);
    alu_case("sltu", 12'h008, F_GRWE, 16'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd0);
    alu_case("and",  12'h010, F_GRWE, 16'h0, 32'hF0F0FFFF, 32'h0FF0000F, 32'h0, 32'h00F0000F);
    alu_case("nor",  12'h020, F_GRWE, 16'h0, 32'hF0F00000, 32'h0F000000, 32'h0, 32'h000FFFFF);
    alu_case("ori",  12'h040, F_ZIMM, 16'h8001, 32'h12340000, 32'h0, 32'h0, 32'h12348001);
    alu_case("xor",  12'h080, F_GRWE, 16'h0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'hF0F0F0F0);
    alu_case("sll",  12'h100, F_SA, 16'h0100, 32'h0, 32'd1, 32'h0, 32'd16);
    alu_case("srl",  12'h200, F_SA, 16'h0100, 32'h0, 32'h80000000, 32'h0, 32'h08000000);
    alu_case("sra",  12'h400, F_SA, 16'h0100, 32'h0, 32'h80000000, 32'h0, 32'hF8000000);
    alu_case("srav", 12'h400, F_GRWE, 16'h0, 32'd33, 32'h80000000, 32'h0, 32'hC0000000);
    alu_case("lui",  12'h800, F_GRWE, 16'h1234, 32'h0, 32'h0, 32'h0, 32'h12340000);
    alu_case("addiu_neg", 12'h001, F_SIMM, 16'hFFFF, 32'd10, 32'h0, 32'h0, 32'd9);
    alu_case("jal_link", 12'h001, F_PC | F_S8, 16'h0, 32'h0, 32'h0, 32'h00001000, 32'h00001008);

    send(mk(12'h000, F_MUL, 16'h0, 32'hFFFFFFFD, 32'd4, 32'h0));
    chk("mult_to_ms_valid", es_to_ms_valid, 1);
    alu_case("mult_mfhi", 12'h000, F_HIRE, 16'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    alu_case("mult_mflo", 12'h000, F_LORE, 16'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF4);
    send(mk(12'h000, F_MULU, 16'h0, 32'hFFFFFFFF, 32'd2, 32'h0));
    alu_case("multu_mfhi", 12'h000, F_HIRE, 16'h0, 32'h0, 32'h0, 32'h0, 32'h00000001);
    alu_case("multu_mflo", 12'h000, F_LORE, 16'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE);
    send(mk(12'h000, F_HIWE, 16'h0, 32'h12345678, 32'h0, 32'h0));
    alu_case("mthi_mfhi", 12'h000, F_HIRE, 16'h0, 32'h0, 32'h0, 32'h0, 32'h12345678);
    alu_case("mthi_lo_kept", 12'h000, F_LORE, 16'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE);
    send(mk(12'h000, F_LOWE, 16'h0, 32'hCAFEF00D, 32'h0, 32'h0));
    alu_case("mtlo_mflo", 12'h000, F_LORE, 16'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D);

    div_case("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    div_case("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    div_case("divu_9_0", F_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);
    div_case("div_20_m6", F_DIV, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd2);

    // Stalled store: ES empties first, then SW sits with ms_allowin low for 3 cycles.
    @(negedge clk);
    wr_base = wr_cnt;
    ms_allowin = 1'b0;
    send(mk(12'h001, F_SIMM | F_MEMWE, 16'h0000, 32'h00000100, 32'h000000A5, 32'h0));
    wen_seen = 0;
    for (int i = 0; i < 3; i++) begin
      wen_seen = wen_seen | {27'b0, data_sram_en, data_sram_wen};
      @(negedge clk);
    end
    chk("sw_stall_no_req", wen_seen, 0);
    ms_allowin = 1'b1;
    #1;
    chk("sw_wen", data_sram_wen, 32'hF);
    chk("sw_en", data_sram_en, 1);
    chk("sw_addr", data_sram_addr, 32'h100);
    chk("sw_wdata", data_sram_wdata, 32'hA5);
    @(negedge clk);
    chk("sw_wen_after", data_sram_wen, 0);
    chk("sw_write_count", wr_cnt - wr_base, 1);

    send(mk(12'h001, F_LOAD | F_SIMM | F_GRWE, 16'hFFFC, 32'h00000200, 32'h0, 32'h0));
    chk("lw_en", data_sram_en, 1);
    chk("lw_wen", data_sram_wen, 0);
    chk("lw_addr", data_sram_addr, 32'h000001FC);
    chk("lw_load_flag", es_to_ms_bus[70], 1);

    // Reset in the middle of a divide.
    send(mk(12'h000, F_DIVU, 16'h0, 32'd50, 32'd3, 32'h0));
    repeat (11) @(negedge clk);
    chk("div_mid_busy", 32'(dut.u_div.state), 32'(DIV_BUSY));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_es_valid", es_valid, 0);
    chk("rst_mid_state", 32'(dut.u_div.state), 32'(DIV_IDLE));
    reset = 1'b0;
    div_case("divu_8_2", F_DIVU, 32'd8, 32'd2, 32'd4, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
